id_operand_latch: RTL

- ID-to-EX operand stage; sits directly downstream of the forwarding unit.
- Selects each source operand per cycle in this order: live forwarded data, then held data, then register-file data.
- Keeps operands correct across multi-cycle ID stalls using a per-operand hold buffer, so operands do not go stale while EX/MEM/WB results retire.
- Drives the ID/EX pipeline register; inserts a bubble on load-use stall and clears on flush.

---
 rtl/id_operand_latch_pkg.sv | 17 +
 rtl/id_operand_latch_hold.sv | 64 ++++++
 rtl/id_operand_latch.sv | 125 ++++++++++++
 3 files changed

// File: rtl/id_operand_latch_pkg.sv
// Shared constants for the ID-to-EX operand stage: stall bus layout,
// register-bus width and the instruction word used for pipeline bubbles.
package id_operand_latch_pkg;

   localparam int STALL_W  = 6;
   localparam int REG_W    = 32;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/id_operand_latch_hold.sv
// Per-operand resolve plus hold buffer: keeps a value captured during an
// ID stall so it stays correct after its producer has left the pipeline.
module id_operand_hold
   import id_operand_latch_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   input  logic              sel_forward,
   input  logic [DATA_W-1:0] forward_data,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              stall_id,
   input  logic              flush,
   output logic [DATA_W-1:0] operand
);

   logic              hold_valid;
   logic [DATA_W-1:0] hold_data;
   logic [ADDR_W-1:0] hold_addr;
   logic              tag_hit;
   logic              wb_hit;

   assign tag_hit = hold_valid && (hold_addr == raddr);
   assign wb_hit  = wb_we && (wb_waddr == raddr) && (raddr != '0);

   // resolve order: r0, live forward, held value, register file
   always_comb begin
      operand = rf_rdata;
      if (raddr == '0)
         operand = '0;
      else if (sel_forward)
         operand = forward_data;
      else if (tag_hit)
         operand = hold_data;
   end

   // capture while ID stalls; forward beats WB as the younger producer
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         hold_addr  <= '0;
      end else if (flush || !stall_id) begin
         hold_valid <= 1'b0;
      end else if (sel_forward) begin
         hold_valid <= 1'b1;
         hold_data  <= forward_data;
         hold_addr  <= raddr;
      end else if (wb_hit) begin
         hold_valid <= 1'b1;
         hold_data  <= wb_wdata;
         hold_addr  <= raddr;
      end else if (hold_addr != raddr) begin
         hold_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/id_operand_latch.sv
// ID/EX pipeline register with per-operand hold buffers.
// Optional: define PIPE_LOAD_STALL_CNT_EN to add the load_stall_cnt counter.
module id_operand_latch
   import id_operand_latch_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [PC_W-1:0]    id_pc,
   input  logic [31:0]        id_inst,
   input  logic [ADDR_W-1:0]  rs_rf_raddr,
   input  logic [ADDR_W-1:0]  rt_rf_raddr,
   input  logic [DATA_W-1:0]  rf_rdata1,
   input  logic [DATA_W-1:0]  rf_rdata2,
   input  logic               sel_rs_forward,
   input  logic               sel_rt_forward,
   input  logic [DATA_W-1:0]  rs_forward_data,
   input  logic [DATA_W-1:0]  rt_forward_data,
   input  logic               stall_for_load,
   input  logic               wb_we,
   input  logic [ADDR_W-1:0]  wb_waddr,
   input  logic [DATA_W-1:0]  wb_wdata,
`ifdef PIPE_LOAD_STALL_CNT_EN
   output logic [31:0]        load_stall_cnt,
`endif
   output logic               ex_valid,
   output logic [PC_W-1:0]    ex_pc,
   output logic [31:0]        ex_inst,
   output logic [DATA_W-1:0]  ex_rs_data,
   output logic [DATA_W-1:0]  ex_rt_data,
   output logic               stallreq_id
);

   logic              stall_id;
   logic              stall_ex;
   logic [DATA_W-1:0] rs_operand;
   logic [DATA_W-1:0] rt_operand;

   assign stall_id = stall[STALL_ID];
   assign stall_ex = stall[STALL_EX];

   id_operand_hold #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_rs_hold (
      .clk         (clk),
      .rst         (rst),
      .raddr       (rs_rf_raddr),
      .rf_rdata    (rf_rdata1),
      .sel_forward (sel_rs_forward),
      .forward_data(rs_forward_data),
      .wb_we       (wb_we),
      .wb_waddr    (wb_waddr),
      .wb_wdata    (wb_wdata),
      .stall_id    (stall_id),
      .flush       (flush),
      .operand     (rs_operand)
   );

   id_operand_hold #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_rt_hold (
      .clk         (clk),
      .rst         (rst),
      .raddr       (rt_rf_raddr),
      .rf_rdata    (rf_rdata2),
      .sel_forward (sel_rt_forward),
      .forward_data(rt_forward_data),
      .wb_we       (wb_we),
      .wb_waddr    (wb_waddr),
      .wb_wdata    (wb_wdata),
      .stall_id    (stall_id),
      .flush       (flush),
      .operand     (rt_operand)
   );

   // ID/EX register: clear, bubble, advance or hold
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ex_valid   <= 1'b0;
         ex_pc      <= '0;
         ex_inst    <= NOP_INST;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
      end else if (stall_id && !stall_ex) begin
         ex_valid   <= 1'b0;
         ex_pc      <= '0;
         ex_inst    <= NOP_INST;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
      end else if (!stall_id) begin
         ex_valid   <= id_valid;
         ex_pc      <= id_pc;
         ex_inst    <= id_inst;
         ex_rs_data <= rs_operand;
         ex_rt_data <= rt_operand;
      end
   end

   // registered load-use request toward the stall controller
   always_ff @(posedge clk) begin
      if (rst || flush)
         stallreq_id <= 1'b0;
      else
         stallreq_id <= stall_for_load;
   end

`ifdef PIPE_LOAD_STALL_CNT_EN
   // saturating count of load-use stall cycles; survives flushes
   always_ff @(posedge clk) begin
      if (rst)
         load_stall_cnt <= '0;
      else if (stall_for_load && stall_id && (load_stall_cnt != 32'hFFFF_FFFF))
         load_stall_cnt <= load_stall_cnt + 32'd1;
   end
`endif

endmodule
